// File: rtl/nn_train_sched_if.sv
// Handshake/bus bundle between the training sequencer and its environment.
// The sequencer side uses the slave modport; the driver/testbench side uses master.
interface nn_train_sched_if #(
  parameter int unsigned BITS = 16
);
  logic            start;
  logic [BITS-1:0] TRAIN;
  logic [BITS-1:0] VALID;
  logic [BITS-1:0] EPOCH;
  logic            arch_done;
  logic            arch_hit;
  logic            TR;
  logic            VL;
  logic            SW;
  logic            arch_go;
  logic            arch_train;
  logic            busy;
  logic            done;
  logic [BITS-1:0] epoch_cnt;
  logic [BITS-1:0] best_hits;

  modport master (
    output start, TRAIN, VALID, EPOCH, arch_done, arch_hit,
    input  TR, VL, SW, arch_go, arch_train, busy, done, epoch_cnt, best_hits
  );

  modport slave (
    input  start, TRAIN, VALID, EPOCH, arch_done, arch_hit,
    output TR, VL, SW, arch_go, arch_train, busy, done, epoch_cnt, best_hits
  );
endinterface

// File: rtl/nn_train_sched.sv
// Epoch/sample sequencer for the NN training loop.
// Issues TR/VL pattern strobes, launches the datapath per sample, tallies
// validation hits and commands a weight store (SW) on accuracy improvement.
// Optional macro NN_EARLY_STOP_EN: stop after PATIENCE epochs without improvement.
module nn_train_sched #(
  parameter int unsigned BITS = 16
`ifdef NN_EARLY_STOP_EN
  , parameter int unsigned PATIENCE = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  nn_train_sched_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, T_ISSUE, T_LAUNCH, T_WAIT, V_ISSUE, V_LAUNCH, V_WAIT, EVAL, FIN
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] hits_q, hits_d;
  logic [BITS-1:0] epoch_q, epoch_d;
  logic [BITS-1:0] best_q, best_d;
  logic            busy_q, busy_d;
  logic            tr_q, tr_d;
  logic            vl_q, vl_d;
  logic            sw_q, sw_d;
  logic            go_q, go_d;
  logic            train_q, train_d;
  logic            done_q, done_d;
  logic [BITS-1:0] cnt_inc;
`ifdef NN_EARLY_STOP_EN
  logic [BITS-1:0] stall_q, stall_d;
`endif

  // Next-state, counter updates and look-ahead registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hits_d  = hits_q;
    epoch_d = epoch_q;
    best_d  = best_q;
    busy_d  = busy_q;
    cnt_inc = cnt_q + BITS'(1);
`ifdef NN_EARLY_STOP_EN
    stall_d = stall_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          epoch_d = '0;
          best_d  = '0;
          cnt_d   = '0;
          hits_d  = '0;
          busy_d  = 1'b1;
`ifdef NN_EARLY_STOP_EN
          stall_d = '0;
`endif
          if (bus.EPOCH == '0)      state_d = FIN;
          else if (bus.TRAIN != '0) state_d = T_ISSUE;
          else if (bus.VALID != '0) state_d = V_ISSUE;
          else                      state_d = EVAL;
        end
      end
      T_ISSUE:  state_d = T_LAUNCH;
      T_LAUNCH: state_d = T_WAIT;
      T_WAIT: begin
        if (bus.arch_done) begin
          if (cnt_inc == bus.TRAIN) begin
            cnt_d   = '0;
            state_d = (bus.VALID != '0) ? V_ISSUE : EVAL;
          end else begin
            cnt_d   = cnt_inc;
            state_d = T_ISSUE;
          end
        end
      end
      V_ISSUE:  state_d = V_LAUNCH;
      V_LAUNCH: state_d = V_WAIT;
      V_WAIT: begin
        if (bus.arch_done) begin
          if (bus.arch_hit) hits_d = hits_q + BITS'(1);
          if (cnt_inc == bus.VALID) begin
            cnt_d   = '0;
            state_d = EVAL;
          end else begin
            cnt_d   = cnt_inc;
            state_d = V_ISSUE;
          end
        end
      end
      EVAL: begin
        // sw_q already holds this epoch's store decision
        if (sw_q) best_d = hits_q;
        epoch_d = epoch_q + BITS'(1);
        hits_d  = '0;
`ifdef NN_EARLY_STOP_EN
        stall_d = sw_q ? '0 : stall_q + BITS'(1);
        if (epoch_d == bus.EPOCH || stall_d == BITS'(PATIENCE)) state_d = FIN;
`else
        if (epoch_d == bus.EPOCH) state_d = FIN;
`endif
        else if (bus.TRAIN != '0) state_d = T_ISSUE;
        else if (bus.VALID != '0) state_d = V_ISSUE;
        else                      state_d = EVAL;
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered Moore-style: decoded from the state being entered.
    tr_d    = (state_d == T_ISSUE);
    vl_d    = (state_d == V_ISSUE);
    go_d    = (state_d == T_LAUNCH) || (state_d == V_LAUNCH);
    train_d = (state_d == T_LAUNCH);
    done_d  = (state_d == FIN);
    sw_d    = (state_d == EVAL) && (bus.VALID != '0) &&
              ((epoch_d == '0) || (hits_d > best_d));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hits_q  <= '0;
      epoch_q <= '0;
      best_q  <= '0;
      busy_q  <= 1'b0;
      tr_q    <= 1'b0;
      vl_q    <= 1'b0;
      sw_q    <= 1'b0;
      go_q    <= 1'b0;
      train_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef NN_EARLY_STOP_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hits_q  <= hits_d;
      epoch_q <= epoch_d;
      best_q  <= best_d;
      busy_q  <= busy_d;
      tr_q    <= tr_d;
      vl_q    <= vl_d;
      sw_q    <= sw_d;
      go_q    <= go_d;
      train_q <= train_d;
      done_q  <= done_d;
`ifdef NN_EARLY_STOP_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign bus.TR         = tr_q;
  assign bus.VL         = vl_q;
  assign bus.SW         = sw_q;
  assign bus.arch_go    = go_q;
  assign bus.arch_train = train_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.epoch_cnt  = epoch_q;
  assign bus.best_hits  = best_q;

endmodule
